bit_serializer: RTL and testbench

Parallel-to-serial front end for the serial pattern detectors (e.g. the 11010 detector).
- Accepts parallel words through a valid/ready handshake.
- Shifts each word out one bit per clock on a single serial line that drives the detector's serial input.
- Double-buffered (shift register plus one holding register), so consecutive words stream with no idle cycle between them.

---
 rtl/bit_serializer.sv | 224 ++++++++++++++++++++++
 tb/tb_bit_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial front end for the serial pattern detectors. Words arrive
// through a valid/ready handshake and leave one bit per clock on a single
// serial line. A shift register plus one holding register let consecutive
// words stream with no idle cycle between them.
//
// Parameters:
//   WIDTH      - bits per word (>= 2)
//   MSB_FIRST  - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   IDLE_LEVEL - level driven on out while no word is being shifted
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   data_in    in   parallel word to transmit (WIDTH bits)
//   load_valid in   data_in is valid
//   load_ready out  a word can be accepted this cycle
//   out        out  serial bit stream
//   out_valid  out  out carries a data bit this cycle
//   busy       out  a word sits in the shift or holding register
//   done       out  high while the last bit of a word is on out
//
// All outputs come straight from flops. Their next values are derived from the
// next-state values of the datapath, so they line up with the bit that the
// shift register presents after the same edge.
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Registers
    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hr;
    logic             r_hr_full;

    logic             r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;

    // Next-state / combinational wires
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_hr_nxt;
    logic             w_hr_full_nxt;
    logic             w_accept;

    logic             w_out_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_load_ready_nxt;

    // Bit currently presented by a shift register image.
    function automatic logic f_head_bit(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST) begin
            return sr[WIDTH-1];
        end else begin
            return sr[0];
        end
    endfunction

    // Shift register image after moving one bit toward the output end.
    function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST) begin
            return {sr[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, sr[WIDTH-1:1]};
        end
    endfunction

    // load_ready is the registered copy of ~hr_full, so acceptance uses it.
    assign w_accept = load_valid & r_load_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_cnt_nxt     = r_cnt;
        w_hr_nxt      = r_hr;
        w_hr_full_nxt = r_hr_full;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Holding register is empty in IDLE: go straight to SR.
                    w_sr_nxt    = data_in;
                    w_cnt_nxt   = CNT_LAST;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt != {CW{1'b0}}) begin
                    w_sr_nxt  = f_shift(r_sr);
                    w_cnt_nxt = r_cnt - CW'(1);
                    if (w_accept) begin
                        w_hr_nxt      = data_in;
                        w_hr_full_nxt = 1'b1;
                    end else begin
                        w_hr_full_nxt = r_hr_full;
                    end
                end else if (r_hr_full) begin
                    // Last bit: buffered word wins; load_ready was low, so
                    // no new word can arrive on this edge.
                    w_sr_nxt      = r_hr;
                    w_hr_full_nxt = 1'b0;
                    w_cnt_nxt     = CNT_LAST;
                end else if (w_accept) begin
                    // Last bit with an empty buffer: new word follows gaplessly.
                    w_sr_nxt  = data_in;
                    w_cnt_nxt = CNT_LAST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_hr_full_nxt = 1'b0;
            end
        endcase
    end

    // Output next values, derived from the post-edge datapath.
    always_comb begin
        w_out_nxt        = IDLE_LEVEL;
        w_out_valid_nxt  = 1'b0;
        w_done_nxt       = 1'b0;
        w_busy_nxt       = w_hr_full_nxt;
        w_load_ready_nxt = ~w_hr_full_nxt;
        unique case (w_state_nxt)
            ST_SHIFT: begin
                w_out_nxt       = f_head_bit(w_sr_nxt);
                w_out_valid_nxt = 1'b1;
                w_done_nxt      = (w_cnt_nxt == {CW{1'b0}});
                w_busy_nxt      = 1'b1;
            end
            ST_IDLE: begin
                w_out_nxt       = IDLE_LEVEL;
                w_out_valid_nxt = 1'b0;
                w_done_nxt      = 1'b0;
            end
            default: begin
                w_out_nxt       = IDLE_LEVEL;
                w_out_valid_nxt = 1'b0;
                w_done_nxt      = 1'b0;
            end
        endcase
    end

    // Datapath registers: shift register, counter, holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr      <= {WIDTH{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_hr      <= {WIDTH{1'b0}};
            r_hr_full <= 1'b0;
        end else begin
            r_sr      <= w_sr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hr      <= w_hr_nxt;
            r_hr_full <= w_hr_full_nxt;
        end
    end

    // Output registers; reset forces them idle without waiting for an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out        <= IDLE_LEVEL;
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_out        <= w_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_load_ready <= w_load_ready_nxt;
        end
    end

    assign out        = r_out;
    assign out_valid  = r_out_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule

// File: tb/tb_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_bit_serializer
//
// Two instances: WIDTH=5 MSB-first and WIDTH=8 LSB-first. Every accepted word
// pushes its expected bits (with the done flag for the last bit) onto a
// per-instance queue; a negedge monitor pops one entry per out_valid cycle.
// Because the serializer streams accepted words gaplessly, the monitor also
// expects out_valid and busy to equal "queue non-empty" and load_ready to be
// high exactly when at most one word's worth of bits is outstanding.
// -----------------------------------------------------------------------------
module tb_bit_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;

    logic [4:0] d5 = 5'd0;
    logic       v5 = 1'b0;
    logic       lr5, o5, ov5, b5, dn5;

    logic [7:0] d8 = 8'd0;
    logic       v8 = 1'b0;
    logic       lr8, o8, ov8, b8, dn8;

    int         n_vec = 0;
    int         n_err = 0;

    logic [1:0] q5[$];
    logic [1:0] q8[$];
    logic [4:0] hist5 = 5'd0;
    logic [7:0] hist8 = 8'd0;

    bit_serializer #(.WIDTH(5), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut5 (
        .clk(clk), .reset(reset), .data_in(d5), .load_valid(v5),
        .load_ready(lr5), .out(o5), .out_valid(ov5), .busy(b5), .done(dn5)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .data_in(d8), .load_valid(v8),
        .load_ready(lr8), .out(o8), .out_valid(ov8), .busy(b8), .done(dn8)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard for the 5-bit MSB-first instance.
    always @(negedge clk) begin : mon5
        int sz;
        logic [1:0] e;
        sz = q5.size();
        check_val("valid5", {31'd0, ov5}, {31'd0, sz != 0});
        check_val("busy5", {31'd0, b5}, {31'd0, sz != 0});
        check_val("ready5", {31'd0, lr5}, {31'd0, sz <= 5});
        if (ov5 && sz != 0) begin
            e = q5.pop_front();
            check_val("out5", {31'd0, o5}, {31'd0, e[0]});
            check_val("done5", {31'd0, dn5}, {31'd0, e[1]});
            hist5 = {hist5[3:0], o5};
        end else begin
            check_val("idle5", {31'd0, o5}, 32'd0);
            check_val("done5_idle", {31'd0, dn5}, 32'd0);
        end
    end

    // Monitor / scoreboard for the 8-bit LSB-first instance.
    always @(negedge clk) begin : mon8
        int sz;
        logic [1:0] e;
        sz = q8.size();
        check_val("valid8", {31'd0, ov8}, {31'd0, sz != 0});
        check_val("busy8", {31'd0, b8}, {31'd0, sz != 0});
        check_val("ready8", {31'd0, lr8}, {31'd0, sz <= 8});
        if (ov8 && sz != 0) begin
            e = q8.pop_front();
            check_val("out8", {31'd0, o8}, {31'd0, e[0]});
            check_val("done8", {31'd0, dn8}, {31'd0, e[1]});
            hist8 = {hist8[6:0], o8};
        end else begin
            check_val("idle8", {31'd0, o8}, 32'd0);
            check_val("done8_idle", {31'd0, dn8}, 32'd0);
        end
    end

    // Present a word, hold until accepted, then queue its expected bits.
    task automatic send5(input logic [4:0] w);
        logic rdy;
        logic acc;
        acc = 1'b0;
        d5 = w;
        v5 = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            rdy = lr5;
            @(posedge clk);
            acc = rdy;
        end
        #1;
        v5 = 1'b0;
        check_val("accept5", {31'd0, acc}, 32'd1);
        if (acc) begin
            for (int i = 0; i < 5; i++) q5.push_back({i == 4, w[4-i]});
        end
    endtask

    task automatic send8(input logic [7:0] w);
        logic rdy;
        logic acc;
        acc = 1'b0;
        d8 = w;
        v8 = 1'b1;
        for (int k = 0; k < 40 && !acc; k++) begin
            @(negedge clk);
            rdy = lr8;
            @(posedge clk);
            acc = rdy;
        end
        #1;
        v8 = 1'b0;
        check_val("accept8", {31'd0, acc}, 32'd1);
        if (acc) begin
            for (int i = 0; i < 8; i++) q8.push_back({i == 7, w[i]});
        end
    endtask

    initial begin
        // Reset state
        #1 reset = 1'b1;
        #2;
        check_val("rst_out5", {31'd0, o5}, 32'd0);
        check_val("rst_valid5", {31'd0, ov5}, 32'd0);
        check_val("rst_busy5", {31'd0, b5}, 32'd0);
        check_val("rst_done8", {31'd0, dn8}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rel_ready5", {31'd0, lr5}, 32'd1);
        check_val("rel_ready8", {31'd0, lr8}, 32'd1);

        // Single 11010 word
        send5(5'b11010);
        repeat (8) @(posedge clk);
        #1 check_val("det11010", {27'd0, hist5}, 32'b11010);

        // Back-to-back: second word lands in the holding register
        send5(5'b11010);
        send5(5'b10110);
        repeat (13) @(posedge clk);
        #1 check_val("b2b_tail", {27'd0, hist5}, 32'b10110);

        // Word accepted exactly on the last-bit edge with HR empty
        send5(5'b11010);
        repeat (4) @(posedge clk);
        #1;
        send5(5'b10011);
        repeat (8) @(posedge clk);
        #1 check_val("last_edge", {27'd0, hist5}, 32'b10011);

        // LSB-first A5
        send8(8'hA5);
        repeat (10) @(posedge clk);
        #1 check_val("lsb_a5", {24'd0, hist8}, 32'hA5);

        // Backpressure: third word waits while SR and HR are both occupied
        send8(8'h3C);
        send8(8'hC3);
        send8(8'h96);
        repeat (30) @(posedge clk);
        #1 check_val("bp_tail", {24'd0, hist8}, 32'h69);

        // Reset during the third bit of FF with a word in HR
        send8(8'hFF);
        send8(8'h5A);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("mid_out8", {31'd0, o8}, 32'd0);
        check_val("mid_valid8", {31'd0, ov8}, 32'd0);
        check_val("mid_busy8", {31'd0, b8}, 32'd0);
        check_val("mid_done8", {31'd0, dn8}, 32'd0);
        q8.delete();
        q5.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send8(8'h81);
        repeat (10) @(posedge clk);
        #1 check_val("post_rst", {24'd0, hist8}, 32'h81);

        check_val("q5_drained", q5.size(), 32'd0);
        check_val("q8_drained", q8.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
